// File: rtl/ser_rx_monitor.sv
// ser_rx_monitor: oversampling 8N1 UART receive monitor with a show-ahead FIFO,
// sticky framing/overflow flags and a newline counter.
module ser_rx_monitor #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DIV_WIDTH-1:0]  cfg_divider,
    input  logic                  ser_rx,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic                  clr_flags,
    output logic                  frame_err,
    output logic                  overflow,
    output logic [LCNT_WIDTH-1:0] line_count,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t                state_q;
    logic                  s1_q, rx_s_q;
    logic [DIV_WIDTH-1:0]  div_q, cnt_q;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic                  frame_err_q, overflow_q;
    logic [LCNT_WIDTH-1:0] line_q;
    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [AW:0]           wr_q, rd_q;

    logic tick_d, push_d, fe_set_d, empty_d, full_d, pop_d, accept_d, drop_d;

    always_comb begin
        tick_d   = cnt_q == '0;
        push_d   = state_q == STOP && tick_d && rx_s_q;
        fe_set_d = state_q == STOP && tick_d && !rx_s_q;
        empty_d  = wr_q == rd_q;
        full_d   = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
        pop_d    = !empty_d && rx_ready;
        // a simultaneous pop frees the slot, so a push into a full FIFO still lands
        accept_d = push_d && (!full_d || pop_d);
        drop_d   = push_d && full_d && !pop_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            rx_s_q  <= 1'b1;
            div_q   <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            s1_q   <= ser_rx;
            rx_s_q <= s1_q;
            case (state_q)
                IDLE: if (!rx_s_q) begin
                    div_q   <= cfg_divider;
                    cnt_q   <= cfg_divider >> 1;
                    state_q <= START;
                end
                START: if (!tick_d) cnt_q <= cnt_q - DIV_WIDTH'(1);
                    else if (rx_s_q) state_q <= IDLE;
                    else begin
                        cnt_q   <= div_q - DIV_WIDTH'(1);
                        bit_q   <= '0;
                        state_q <= DATA;
                    end
                DATA: if (!tick_d) cnt_q <= cnt_q - DIV_WIDTH'(1);
                    else begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        cnt_q   <= div_q - DIV_WIDTH'(1);
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end
                STOP: if (!tick_d) cnt_q <= cnt_q - DIV_WIDTH'(1);
                    else state_q <= rx_s_q ? IDLE : BRK;
                BRK: if (rx_s_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q        <= '0;
            rd_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            line_q      <= '0;
        end else begin
            if (accept_d) wr_q <= wr_q + (AW+1)'(1);
            if (pop_d) rd_q <= rd_q + (AW+1)'(1);
            frame_err_q <= fe_set_d || (frame_err_q && !clr_flags);
            overflow_q  <= drop_d || (overflow_q && !clr_flags);
            if (accept_d && shift_q == 8'h0A) line_q <= line_q + LCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept_d) mem_q[wr_q[AW-1:0]] <= shift_q;
    end

    assign rx_valid   = !empty_d;
    assign rx_data    = rx_valid ? mem_q[rd_q[AW-1:0]] : 8'h00;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign line_count = line_q;
    assign busy       = state_q != IDLE;
endmodule
